// File: rtl/board_pkg.sv
// Shared definitions for the minesweeper board setup controller.
//   - board geometry and cell bit positions
//   - cell_t storage word, FSM state enum, neighbour lookup result
//   - LFSR step function and neighbour-offset helper
package board_pkg;

  localparam int BOARD_DIM  = 8;
  localparam int CNT_LSB    = 0;
  localparam int CNT_MSB    = 3;
  localparam int REVEAL_BIT = 4;
  localparam int FLAG_BIT   = 5;
  localparam int MINE_BIT   = 6;

  localparam logic [3:0]  CNT_SAT   = 4'd8;
  // Galois feedback for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [8:0] cell_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_GEN,
    S_RD,
    S_CHK,
    S_NBR_RD,
    S_NBR_WR,
    S_FIN
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [5:0] addr;
  } nbr_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  // idx 0..7 walks the 3x3 window row-major, skipping the centre.
  // Off-board neighbours come back with valid=0 (no wrap-around).
  function automatic nbr_t nbr_of(input logic [5:0] center, input logic [2:0] idx);
    int   pos;
    int   r;
    int   c;
    nbr_t n;
    pos     = (idx < 3'd4) ? int'(idx) : int'(idx) + 1;
    r       = int'(center[5:3]) + pos / 3 - 1;
    c       = int'(center[2:0]) + pos % 3 - 1;
    n.valid = (r >= 0) && (r < BOARD_DIM) && (c >= 0) && (c < BOARD_DIM);
    n.addr  = n.valid ? 6'(r * BOARD_DIM + c) : center;
    return n;
  endfunction

endpackage

// File: rtl/board_setup_lfsr16.sv
// 16-bit Galois LFSR used to draw mine candidates.
//   clk, rst   : clock, async active-low reset (state returns to SEED_DEFAULT)
//   load, seed : load a new seed (takes priority over step)
//   step       : advance one position
//   value      : low six bits of the current state (a board cell index)
module lfsr16
  import board_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [5:0]  value
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load)      lfsr_d = seed;
    else if (step) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= SEED_DEFAULT;
    else      lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q[5:0];

endmodule

// File: rtl/board_setup_ctrl.sv
// Builds a fresh 8x8 minesweeper board in an external synchronous RAM:
// clears every cell, places mine_count mines at LFSR-drawn positions
// (rejecting duplicates) and bumps the adjacent-mine count of each neighbour.
//   clk, rst              : clock, async active-low reset
//   start                 : one-cycle build request (ignored while not idle)
//   mine_count, seed      : build parameters, captured on accepted start
//   cell_addr/we/wdata    : RAM write port / read address
//   cell_rdata            : RAM read data, one cycle after cell_addr
//   busy, done, err       : status; done/err are one-cycle pulses
//
// state    | meaning
// IDLE     | waiting for start
// CLEAR    | writing zero to cells 0..63
// GEN      | present current LFSR draw as candidate, step LFSR
// RD       | wait for candidate read data
// CHK      | reject duplicate, or mark mine and begin neighbour walk
// NBR_RD   | present next on-board neighbour (off-board ones skipped)
// NBR_WR   | write neighbour back with saturating count+1
// FIN      | done pulse, back to IDLE
module board_setup_ctrl
  import board_pkg::*;
#(
  parameter int          MAX_TRIES    = 255,
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  mine_count,
  input  logic [15:0] seed,
  output logic [5:0]  cell_addr,
  input  logic [8:0]  cell_rdata,
  output logic [8:0]  cell_wdata,
  output logic        cell_we,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int            TW        = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

  state_e        state_q, state_d;
  logic [5:0]    clr_q, clr_d;
  logic [5:0]    cand_q, cand_d;
  logic [5:0]    mines_q, mines_d;
  logic [2:0]    nbr_q, nbr_d;
  logic [TW-1:0] tries_q, tries_d, tries_inc;
  logic          err_q, err_d;

  logic          lfsr_load, lfsr_step;
  logic [5:0]    lfsr_val;
  logic [15:0]   seed_eff;
  nbr_t          nbr;
  logic [3:0]    cnt_inc;

  assign seed_eff  = (seed == 16'h0000) ? SEED_DEFAULT : seed;
  assign nbr       = nbr_of(cand_q, nbr_q);
  assign tries_inc = tries_q + TW'(1);
  assign cnt_inc   = (cell_rdata[CNT_MSB:CNT_LSB] >= CNT_SAT) ? cell_rdata[CNT_MSB:CNT_LSB]
                                                             : cell_rdata[CNT_MSB:CNT_LSB] + 4'd1;

  lfsr16 #(.SEED_DEFAULT(SEED_DEFAULT)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_eff),
    .value (lfsr_val)
  );

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    cand_d     = cand_q;
    mines_d    = mines_q;
    nbr_d      = nbr_q;
    tries_d    = tries_q;
    err_d      = 1'b0;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    cell_addr  = 6'd0;
    cell_wdata = '0;
    cell_we    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          clr_d     = 6'd0;
          mines_d   = mine_count;
          tries_d   = '0;
          lfsr_load = 1'b1;
        end
      end
      S_CLEAR: begin
        cell_addr = clr_q;
        cell_we   = 1'b1;
        clr_d     = clr_q + 6'd1;
        if (clr_q == 6'd63) state_d = (mines_q == 6'd0) ? S_FIN : S_GEN;
      end
      S_GEN: begin
        cell_addr = lfsr_val;
        cand_d    = lfsr_val;
        lfsr_step = 1'b1;
        state_d   = S_RD;
      end
      S_RD: begin
        cell_addr = cand_q;
        state_d   = S_CHK;
      end
      S_CHK: begin
        cell_addr = cand_q;
        if (cell_rdata[MINE_BIT]) begin
          tries_d = tries_inc;
          if (tries_inc == TRIES_MAX) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_GEN;
          end
        end else begin
          cell_we              = 1'b1;
          cell_wdata           = cell_rdata;
          cell_wdata[MINE_BIT] = 1'b1;
          tries_d              = '0;
          nbr_d                = 3'd0;
          state_d              = S_NBR_RD;
        end
      end
      S_NBR_RD, S_NBR_WR: begin
        // NBR_RD on a valid neighbour only issues the read; every other
        // case (skip or write-back) finishes the current neighbour.
        if (state_q == S_NBR_RD && nbr.valid) begin
          cell_addr = nbr.addr;
          state_d   = S_NBR_WR;
        end else begin
          if (state_q == S_NBR_WR) begin
            cell_addr                    = nbr.addr;
            cell_we                      = 1'b1;
            cell_wdata                   = cell_rdata;
            cell_wdata[CNT_MSB:CNT_LSB]  = cnt_inc;
          end
          nbr_d = nbr_q + 3'd1;
          if (nbr_q == 3'd7) begin
            mines_d = mines_q - 6'd1;
            state_d = (mines_q == 6'd1) ? S_FIN : S_GEN;
          end else begin
            state_d = S_NBR_RD;
          end
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      clr_q   <= 6'd0;
      cand_q  <= 6'd0;
      mines_q <= 6'd0;
      nbr_q   <= 3'd0;
      tries_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      cand_q  <= cand_d;
      mines_q <= mines_d;
      nbr_q   <= nbr_d;
      tries_q <= tries_d;
      err_q   <= err_d;
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done = (state_q == S_FIN);
  assign err  = err_q;

endmodule

// File: tb/tb_board_setup_ctrl.sv
module tb_board_setup_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start;
  logic [5:0]  mine_count;
  logic [15:0] seed;
  logic [5:0]  cell_addr;
  logic [8:0]  cell_rdata, cell_wdata;
  logic        cell_we, busy, done, err;

  logic        start_t;
  logic [5:0]  cell_addr_t;
  logic [8:0]  cell_wdata_t;
  logic        cell_we_t, busy_t, done_t, err_t;

  int          checks = 0;
  int          errors = 0;

  logic [8:0]  mem [64];
  logic [8:0]  snap [64];
  int          wr_cnt = 0;
  logic        scrub = 1'b0;
  int          corner_lat = 0;

  // Deep boards can need many redraws for the last free cells, so the main
  // instance gets generous headroom; the second instance exercises abort.
  board_setup_ctrl #(.MAX_TRIES(1000)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mine_count (mine_count),
    .seed       (seed),
    .cell_addr  (cell_addr),
    .cell_rdata (cell_rdata),
    .cell_wdata (cell_wdata),
    .cell_we    (cell_we),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // RAM for this instance always reports an occupied cell.
  board_setup_ctrl #(.MAX_TRIES(2)) dut_t (
    .clk        (clk),
    .rst        (rst),
    .start      (start_t),
    .mine_count (6'd3),
    .seed       (16'h0001),
    .cell_addr  (cell_addr_t),
    .cell_rdata (9'h040),
    .cell_wdata (cell_wdata_t),
    .cell_we    (cell_we_t),
    .busy       (busy_t),
    .done       (done_t),
    .err        (err_t)
  );

  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < 64; i++) mem[i] <= 9'h1FF;
    end else if (cell_we) begin
      mem[cell_addr] <= cell_wdata;
      wr_cnt         <= wr_cnt + 1;
    end
    cell_rdata <= mem[cell_addr];
  end

  function automatic int count_mines();
    int n = 0;
    for (int i = 0; i < 64; i++) if (mem[i][6]) n++;
    return n;
  endfunction

  // Cells whose contents differ from {mine, count of neighbouring mines}.
  function automatic int board_bad_cells();
    int bad = 0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n;
        logic [8:0] e;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < 8 &&
                c + dc >= 0 && c + dc < 8 && mem[(r + dr) * 8 + c + dc][6]) n++;
        e = {2'b00, mem[r * 8 + c][6], 2'b00, 4'(n)};
        if (mem[r * 8 + c] !== e) bad++;
      end
    end
    return bad;
  endfunction

  task automatic do_scrub();
    @(negedge clk) scrub = 1'b1;
    @(negedge clk) scrub = 1'b0;
  endtask

  task automatic run_board(input logic [5:0] mc, input logic [15:0] sd, input int pulse_at,
                           output int lat, output int writes, output bit got_done, output bit got_err);
    int base;
    @(negedge clk);
    mine_count = mc;
    seed       = sd;
    start      = 1'b1;
    base       = wr_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; got_done = 1'b0; got_err = 1'b0;
    for (int i = 1; i <= 20000; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (i == pulse_at) begin
        start      = 1'b1;
        mine_count = 6'd5;
        seed       = 16'h5555;
      end
      if (err)  begin got_err = 1'b1;  lat = i; break; end
      if (done) begin got_done = 1'b1; lat = i; break; end
    end
    start  = 1'b0;
    writes = wr_cnt - base;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; start_t = 1'b0; mine_count = 6'd0; seed = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err, cell_we} !== 4'b0000)
      $display("FAIL reset_status got %b want 0000", {busy, done, err, cell_we});
    checks++;
    if (cell_addr !== 6'd0 || cell_wdata !== 9'd0)
      $display("FAIL reset_bus got addr=%0d wdata=%h want 0/000", cell_addr, cell_wdata);
    checks++;
    if ({busy_t, done_t, err_t} !== 3'b000)
      $display("FAIL reset_status_t got %b want 000", {busy_t, done_t, err_t});
    if ({busy, done, err, cell_we} !== 4'b0000 || cell_addr !== 6'd0 || cell_wdata !== 9'd0 ||
        {busy_t, done_t, err_t} !== 3'b000) errors++;
    @(negedge clk) rst = 1'b1;
  endtask

  task automatic test_zero_mines();
    int lat, writes, nz;
    bit gd, ge;
    do_scrub();
    run_board(6'd0, 16'h0000, 0, lat, writes, gd, ge);
    checks++; if (gd !== 1'b1 || lat != 64) begin errors++; $display("FAIL zero_done_latency got done=%0d lat=%0d want 1/64", gd, lat); end
    checks++; if (writes != 64) begin errors++; $display("FAIL zero_writes got %0d want 64", writes); end
    checks++; if (ge !== 1'b0) begin errors++; $display("FAIL zero_err got %0d want 0", ge); end
    nz = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== 9'h000) nz++;
    checks++; if (nz != 0) begin errors++; $display("FAIL zero_cells got %0d nonzero want 0", nz); end
    @(posedge clk); #1;
    checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL zero_done_pulse got done,busy=%b want 00", {done, busy}); end
  endtask

  task automatic test_corner_mine();
    int lat, writes, bad;
    bit gd, ge;
    logic [8:0] e;
    do_scrub();
    // seed 0x0080: first draw lands on cell 0
    run_board(6'd1, 16'h0080, 0, lat, writes, gd, ge);
    corner_lat = lat;
    checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL corner_done got done=%0d err=%0d want 1/0", gd, ge); end
    checks++; if (mem[0] !== 9'h040) begin errors++; $display("FAIL corner_cell0 got %h want 040", mem[0]); end
    bad = 0;
    for (int i = 1; i < 64; i++) begin
      e = (i == 1 || i == 8 || i == 9) ? 9'h001 : 9'h000;
      if (mem[i] !== e) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL corner_neighbours got %0d bad cells want 0", bad); end
    checks++; if (writes != 68) begin errors++; $display("FAIL corner_writes got %0d want 68 (64 clear+1 mine+3 nbr)", writes); end
  endtask

  task automatic test_start_while_busy();
    int lat, writes;
    bit gd, ge;
    do_scrub();
    run_board(6'd1, 16'h0080, 10, lat, writes, gd, ge);
    checks++; if (gd !== 1'b1 || lat != corner_lat) begin errors++; $display("FAIL busy_start_latency got done=%0d lat=%0d want 1/%0d", gd, lat, corner_lat); end
    checks++; if (writes != 68 || mem[0] !== 9'h040 || count_mines() != 1) begin
      errors++; $display("FAIL busy_start_board got writes=%0d cell0=%h mines=%0d want 68/040/1", writes, mem[0], count_mines());
    end
  endtask

  task automatic test_ten_mines();
    int lat1, lat2, writes, diffs;
    bit gd, ge;
    do_scrub();
    run_board(6'd10, 16'h1234, 0, lat1, writes, gd, ge);
    checks++; if (gd !== 1'b1) begin errors++; $display("FAIL ten_done got %0d want 1", gd); end
    checks++; if (count_mines() != 10) begin errors++; $display("FAIL ten_mines got %0d want 10", count_mines()); end
    checks++; if (board_bad_cells() != 0) begin errors++; $display("FAIL ten_counts got %0d bad cells want 0", board_bad_cells()); end
    for (int i = 0; i < 64; i++) snap[i] = mem[i];
    do_scrub();
    run_board(6'd10, 16'h1234, 0, lat2, writes, gd, ge);
    diffs = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== snap[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL ten_repeat_board got %0d differing cells want 0", diffs); end
    checks++; if (lat2 != lat1 || gd !== 1'b1) begin errors++; $display("FAIL ten_repeat_cycles got %0d want %0d", lat2, lat1); end
  endtask

  task automatic test_full_board();
    int lat, writes;
    bit gd, ge;
    do_scrub();
    run_board(6'd63, 16'hBEEF, 0, lat, writes, gd, ge);
    checks++; if (gd !== 1'b1 || ge !== 1'b0) begin errors++; $display("FAIL full_done got done=%0d err=%0d want 1/0", gd, ge); end
    checks++; if (count_mines() != 63) begin errors++; $display("FAIL full_mines got %0d want 63", count_mines()); end
    checks++; if (board_bad_cells() != 0) begin errors++; $display("FAIL full_counts got %0d bad cells want 0", board_bad_cells()); end
  endtask

  task automatic test_max_tries();
    int lat;
    bit got, seen_done;
    @(negedge clk) start_t = 1'b1;
    @(posedge clk);
    #1 start_t = 1'b0;
    lat = 0; got = 1'b0; seen_done = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (done_t) seen_done = 1'b1;
      if (err_t) begin got = 1'b1; lat = i; break; end
    end
    // 64 clear cycles, then GEN/RD/CHK twice -> err register visible at cycle 70
    checks++; if (got !== 1'b1 || lat != 70) begin errors++; $display("FAIL tries_err_latency got err=%0d lat=%0d want 1/70", got, lat); end
    checks++; if (busy_t !== 1'b0) begin errors++; $display("FAIL tries_busy got %0d want 0", busy_t); end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL tries_no_done got %0d want 0", seen_done); end
    @(posedge clk); #1;
    checks++; if ({err_t, busy_t, done_t} !== 3'b000) begin errors++; $display("FAIL tries_err_pulse got %b want 000", {err_t, busy_t, done_t}); end
  endtask

  task automatic test_reset_mid_op();
    int base, lat, writes;
    bit hit, gd, ge;
    do_scrub();
    @(negedge clk);
    mine_count = 6'd1; seed = 16'h0080; start = 1'b1; base = wr_cnt;
    @(posedge clk);
    #1 start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (cell_we && (wr_cnt - base) == 65) begin hit = 1'b1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL midrst_reach_nbr_wr got %0d want 1", hit); end
    // next edge: cell 0 skips neighbour 5, so a restart would show as a CLEAR write
    start = 1'b1;
    @(posedge clk); #1;
    checks++; if ({busy, cell_we} !== 2'b10) begin errors++; $display("FAIL busy_start_ignored got busy,we=%b want 10", {busy, cell_we}); end
    // advance to the next NBR_WR (neighbour 6) and reset in the middle of it
    for (int i = 0; i < 10; i++) begin
      if (cell_we) break;
      @(posedge clk); #1;
    end
    #1 rst = 1'b0;
    #1;
    checks++; if ({busy, done, err, cell_we} !== 4'b0000 || cell_addr !== 6'd0 || cell_wdata !== 9'd0) begin
      errors++; $display("FAIL midrst_async got b,d,e,we=%b addr=%0d wdata=%h want 0000/0/000", {busy, done, err, cell_we}, cell_addr, cell_wdata);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wr_cnt - base != 66) begin errors++; $display("FAIL midrst_no_write got %0d writes want 66", wr_cnt - base); end
    @(negedge clk);
    start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy=%0d want 0", busy); end
    run_board(6'd1, 16'h0080, 0, lat, writes, gd, ge);
    checks++; if (gd !== 1'b1 || mem[0] !== 9'h040 || writes != 68) begin
      errors++; $display("FAIL midrst_rerun got done=%0d cell0=%h writes=%0d want 1/040/68", gd, mem[0], writes);
    end
  endtask

  initial begin
    test_reset();
    do_scrub();
    test_zero_mines();
    test_corner_mine();
    test_start_while_busy();
    test_ten_mines();
    test_full_board();
    test_max_tries();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
